serial_signed_sub_with_saturation: RTL and testbench
====================================================

# serial_signed_sub_with_saturation

Bit-serial signed subtractor with saturation: computes `a - b` on two's-complement WIDTH-bit operands one bit per clock using a single full-adder cell, then clamps overflow to the most-positive or most-negative representable value. It is the inverse-direction companion to the combinational saturating adder and serves area-constrained datapaths where a full-width subtractor is too large. Operands arrive through a valid/ready input handshake; the result leaves through a valid/ready output handshake.

## Interface
- `WIDTH`, 4, operand and result width in bits; legal range is 2 or greater.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands are valid.
- `in_ready` output 1: block accepts operands.
- `a` input WIDTH: minuend, signed.
- `b` input WIDTH: subtrahend, signed.
- `out_valid` output 1: `diff` is valid.
- `out_ready` input 1: consumer accepts `diff`.
- `diff` output WIDTH: saturated `a - b`, signed.
- `overflow` output 1: present only with `SERIAL_SUB_OVERFLOW_FLAG_EN`; the result was clamped.

## Operation
- The FSM has three states: IDLE, RUN, and DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch `a` into shift register A and `~b` into shift register B.
  - Set carry flop to 1, which implements `a + ~b + 1`.
  - Clear bit counter and result register, then go to RUN.
- **RUN:**
  - `in_ready` = 0.
  - Each cycle, the full-adder cell takes A[0], B[0], and carry.
  - The sum bit shifts into the result register at the MSB end, and the result shifts right.
  - The carry flop updates. A and B shift right.
  - The counter increments.
  - When the counter equals WIDTH-1, that cycle processes the MSB. On the same edge:
    - capture `ovf = carry_in_to_msb ^ carry_out_of_msb`
    - capture `sign_a` = MSB of the original `a`, held in a flop from acceptance
    - go to DONE.
- **DONE:**
  - `out_valid` = 1.
  - `diff` = `ovf ? (sign_a ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}}) : result`.
  - Hold `diff` stable while `out_valid & ~out_ready`.
  - On `out_ready`, go to IDLE.
- Saturation rule:
  - overflow is possible only when the signs of `a` and `b` differ
  - a positive `a` clamps to max positive
  - a negative `a` clamps to min negative.
- `in_ready` is 0 in RUN and DONE. There is no overlap of consecutive operations.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready` = 1
  - `out_valid` = 0
  - `diff` = 0
  - `overflow` = 0
  - all internal registers = 0.
- Latency:
  - operands are accepted on edge E0
  - bits are processed on edges E1..E_WIDTH
  - `out_valid` rises after E_WIDTH, i.e. WIDTH cycles after acceptance.
- Throughput: one result per WIDTH+2 cycles when `out_ready` is held 1.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.
- Output stall: DONE is held indefinitely, and `diff` and `overflow` stay constant.
- Reset asserted mid-RUN or mid-DONE:
  - the block returns immediately to IDLE with reset values
  - the partial result is discarded and never presented.
- `a` and `b` are sampled only on the accepting edge. Later changes have no effect.

## Configuration
- `SERIAL_SUB_OVERFLOW_FLAG_EN` defined:
  - the `overflow` output port exists
  - it equals the captured `ovf` while in DONE, and is 0 otherwise.
- Not defined:
  - the port and its register are absent
  - saturation behaviour is identical.

## Structure
- Shared package `sat_arith_pkg` contains:
  - the state enum `sub_state_t` (IDLE, RUN, DONE)
  - function `sat_max(width)` and function `sat_min(width)`, which return the clamp constants.
- Sub-module `serial_full_adder_cell` is combinational. It has inputs `x`, `y`, `cin` and outputs `s`, `cout`, and is instantiated once.
- The counter is `$clog2(WIDTH)` bits wide.

## Test plan
All scenarios use WIDTH=4.
- Reset, then idle: `in_ready`=1, `out_valid`=0, `diff`=0000.
- a=0011, b=0101 (3-5) -> `diff`=1110 (-2), `overflow`=0; `out_valid` rises 4 cycles after acceptance.
- a=0111, b=1111 (7-(-1)) -> `diff`=0111, `overflow`=1. a=0000, b=1000 (0-(-8)) -> `diff`=0111, `overflow`=1.
- a=1000, b=0001 (-8-1) -> `diff`=1000, `overflow`=1. a=1000, b=1000 -> `diff`=0000, `overflow`=0.
- Hold `out_ready`=0 for 5 cycles in DONE -> `diff` stable and `in_ready`=0 throughout; the new `in_valid` is not accepted until after the `out_ready` handshake.
- Assert `rst_n`=0 on the second RUN cycle -> `out_valid` stays 0 and state is IDLE. The next operation, 0010-0001, yields 0001.

Source files
------------

// File: rtl/sat_arith_pkg.sv
// sat_arith_pkg: shared state enum and clamp constants for the saturating arithmetic blocks.
package sat_arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
  function automatic logic [63:0] sat_max(input int width);
    return (64'(1) << (width - 1)) - 64'(1);
  endfunction
  function automatic logic [63:0] sat_min(input int width);
    return 64'(1) << (width - 1);
  endfunction
endpackage

// File: rtl/serial_full_adder_cell.sv
// serial_full_adder_cell: one-bit combinational full adder used by the bit-serial datapath.
module serial_full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/serial_signed_sub_with_saturation.sv
// serial_signed_sub_with_saturation: bit-serial saturating a - b, LSB first, one bit per clock.
// Optional overflow output port enabled by SERIAL_SUB_OVERFLOW_FLAG_EN.
module serial_signed_sub_with_saturation
  import sat_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
  sub_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, ovf_q, ovf_d, sign_q, sign_d;
  logic s, cout;
  serial_full_adder_cell u_fa (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .cin (carry_q),
    .s   (s),
    .cout(cout)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    sign_d  = sign_q;
    if (state_q == IDLE && in_valid) begin
      // a + ~b + 1: the initial carry supplies the two's-complement +1
      a_d     = a;
      b_d     = ~b;
      carry_d = 1'b1;
      cnt_d   = '0;
      res_d   = '0;
      ovf_d   = 1'b0;
      sign_d  = a[WIDTH-1];
      state_d = RUN;
    end else if (state_q == RUN) begin
      res_d   = {s, res_q[WIDTH-1:1]};
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = cout;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        ovf_d   = carry_q ^ cout;
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign diff      = ovf_q ? (sign_q ? SAT_MIN : SAT_MAX) : res_q;
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
  assign overflow  = (state_q == DONE) & ovf_q;
`endif
endmodule

// File: tb/tb_serial_signed_sub_with_saturation.sv
// tb_serial_signed_sub_with_saturation: directed checks of latency, saturation, stall and reset.
module tb_serial_signed_sub_with_saturation;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic in_ready, out_valid;
  logic [3:0] diff;
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
  logic ovf;
`endif
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  serial_signed_sub_with_saturation #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff)
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
    ,
    .overflow (ovf)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] ed,
                    input logic eo, input int stall);
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    chk("in_ready_run", in_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk("out_valid_latency", out_valid, 32'(k == 4));
    end
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      chk("stall_diff", diff, ed);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    chk("diff", diff, ed);
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
    chk("overflow", ovf, eo);
`else
    if (eo === 1'bx) $display("unreachable");
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", out_valid, 0);
    chk("in_ready_after_hs", in_ready, 1);
`ifdef SERIAL_SUB_OVERFLOW_FLAG_EN
    chk("overflow_cleared", ovf, 0);
`endif
  endtask
  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_diff", diff, 4'b0000);
    op(4'b0011, 4'b0101, 4'b1110, 1'b0, 0);
    op(4'b0111, 4'b1111, 4'b0111, 1'b1, 0);
    op(4'b0000, 4'b1000, 4'b0111, 1'b1, 0);
    op(4'b1000, 4'b0001, 4'b1000, 1'b1, 0);
    op(4'b1000, 4'b1000, 4'b0000, 1'b0, 0);
    op(4'b0101, 4'b0010, 4'b0011, 1'b0, 5);
    op(4'b1101, 4'b0011, 4'b1010, 1'b0, 0);
    @(negedge clk);
    a = 4'b0110;
    b = 4'b1001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_in_ready", in_ready, 1);
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_diff", diff, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_out_valid", out_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_out_valid", out_valid, 0);
    end
    op(4'b0010, 4'b0001, 4'b0001, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
